// File: rtl/btn_drv.sv
// btn_drv: synchronises and debounces a raw push-button, and emits press/release/long-press pulses.
// Latency: 2 cycles of synchroniser, then DebSamples sample ticks, then 1 registered cycle to the pulse.
// Backpressure: none; every output is registered and the tick inputs are single-cycle strobes.
// Optional macro BTN_AUTOREPEAT_EN: repeat press_o on every sec_tick_i once a long press has fired.
module btn_drv #(
  parameter int DebSamples = 4,
  parameter int LongSec    = 2,
  parameter int CntW       = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  input  logic       sample_tick_i,
  input  logic       sec_tick_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    DEB_PRESS = 2'b01,
    PRESSED   = 2'b10,
    DEB_REL   = 2'b11
  } state_e;

  localparam logic [CntW-1:0] DEB_MAX  = CntW'(DebSamples);
  localparam logic [CntW-1:0] LONG_MAX = CntW'(LongSec);

  logic            sync1_q, sync2_q;
  logic            s;
  state_e          state_q, state_d;
  logic [CntW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CntW-1:0] sec_cnt_q, sec_cnt_d;
  logic [CntW-1:0] deb_inc, sec_inc;
  logic            long_done_q, long_done_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;

  // Two-flop synchroniser: btn_i is asynchronous to clk_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  assign s       = sync2_q;
  assign deb_inc = deb_cnt_q + CntW'(1);
  assign sec_inc = sec_cnt_q + CntW'(1);

  // Next-state logic: debounce both edges, time the hold in seconds; pulses default low.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d   = DEB_PRESS;
          deb_cnt_d = '0;
        end
      end
      DEB_PRESS: begin
        // A bounce back to 0 wins over a tick in the same cycle.
        if (!s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (sample_tick_i) begin
          if (deb_inc == DEB_MAX) begin
            state_d     = PRESSED;
            deb_cnt_d   = '0;
            level_d     = 1'b1;
            press_d     = 1'b1;
            sec_cnt_d   = '0;
            long_done_d = 1'b0;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end
      end
      PRESSED: begin
        // The button is still debounced-held in this cycle, so a second tick counts even if s just fell.
        if (sec_tick_i) begin
          if (!long_done_q) begin
            sec_cnt_d = sec_inc;
            if (sec_inc == LONG_MAX) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
            end
          end
`ifdef BTN_AUTOREPEAT_EN
          else begin
            press_d = 1'b1;
          end
`endif
        end
        if (!s) begin
          state_d   = DEB_REL;
          deb_cnt_d = '0;
        end
      end
      DEB_REL: begin
        // Returning to PRESSED keeps sec_cnt/long_done so release bounce never restarts the long timer.
        if (s) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (sample_tick_i) begin
          if (deb_inc == DEB_MAX) begin
            state_d   = IDLE;
            deb_cnt_d = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      sec_cnt_q   <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign state_o   = state_q;

endmodule

// File: doc/btn_drv.md
Name: btn_drv

Overview:
- Button driver that consumes the one-cycle tick strobes produced by the frequency-divider counter.
- Synchronises a raw mechanical button and debounces it on sample ticks.
- Emits clean one-cycle press/release events and a long-press event timed in second ticks.
- Sits between the board push-button pin and the control logic, downstream of the divider instances.

Parameters:
DebSamples, 4, consecutive sample_tick_i samples of a stable level required to accept a change (>=1)
LongSec, 2, sec_tick_i strobes with the button held before long_o fires (>=1)
CntW, 4, width of the internal debounce and second counters; must hold max(DebSamples, LongSec)

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous active-low reset
btn_i  input  1  raw button, active-high, asynchronous to clk_i, bouncy
sample_tick_i  input  1  one-cycle debounce sampling strobe from a divider overflow
sec_tick_i  input  1  one-cycle 1 s strobe from a divider overflow
level_o  output  1  debounced button level
press_o  output  1  one-cycle pulse on an accepted press
release_o  output  1  one-cycle pulse on an accepted release
long_o  output  1  one-cycle pulse when the hold reaches LongSec
state_o  output  2  current FSM state, for debug

Behaviour:
- Single clock domain, clk_i. rst_i is asynchronous and active-low; it clears every flop immediately.
- Reset values: all outputs 0, state IDLE (00), counters 0, synchroniser flops 0, long_done 0.
- Synchroniser: two flops on btn_i produce `s`. All FSM decisions use `s`, giving 2 cycles of latency.
- FSM encoding: IDLE=00, DEB_PRESS=01, PRESSED=10, DEB_REL=11.
- IDLE:
  - s=1: go to DEB_PRESS and clear deb_cnt.
- DEB_PRESS:
  - s=0 in any cycle: return to IDLE and clear deb_cnt. An abort has priority over a same-cycle tick.
  - s=1 and sample_tick_i: increment deb_cnt.
  - When a tick would make deb_cnt reach DebSamples: go to PRESSED, set level_o=1, pulse press_o in the next cycle, clear sec_cnt and long_done.
- PRESSED:
  - On sec_tick_i with long_done=0: increment sec_cnt.
  - When sec_cnt reaches LongSec: pulse long_o once, set long_done=1. sec_cnt saturates at LongSec and never wraps.
  - s=0: go to DEB_REL and clear deb_cnt.
- DEB_REL:
  - s=1: return to PRESSED. sec_cnt and long_done are preserved, so bounce never restarts long-press timing.
  - s=0 and sample_tick_i: increment deb_cnt.
  - On reaching DebSamples: go to IDLE, clear level_o, pulse release_o.
  - sec_tick_i is ignored in this state.
- Pulse rules:
  - press_o, release_o and long_o are registered, exactly one clk_i cycle wide, and mutually exclusive in any cycle.
  - press_o and long_o can never coincide because LongSec>=1.
- Tick inputs held high for several cycles are treated as one tick per cycle; the tick source guarantees single-cycle strobes.
- Counters are CntW bits wide and are compared for equality against the parameters. They never overflow because they are cleared or saturate first.
- Reset asserted mid-operation, including mid-pulse: outputs drop asynchronously and the FSM restarts in IDLE. A button still held after reset is re-debounced and produces a fresh press_o.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Once long_done=1 in PRESSED, every following sec_tick_i produces an additional press_o pulse (auto-repeat).
  - No repeats are produced in DEB_REL or after release.
  - long_o still fires exactly once.
- Undefined:
  - press_o fires exactly once per accepted press.
  - No repeat logic is synthesised.

Test Plan:
- Setup for all scenarios: DebSamples=4, LongSec=2, sample_tick every 10 cycles, sec_tick every 100 cycles.
- Reset: hold rst_i=0 with btn_i=1 -> all outputs 0 and state_o=00; release rst_i -> press_o pulses once after 4 sample ticks plus 2 cycles.
- Bounce reject: btn_i=1 for 3 ticks, then 0 for 1 cycle, then 1 -> no press_o at tick 3; press_o pulses after 4 new stable ticks; level_o=1.
- Long press: hold btn_i=1 -> press_o, then long_o after 2 sec_ticks, then no further long_o over 5 more sec_ticks; release -> release_o after 4 ticks, level_o=0.
- Release bounce: while held with sec_cnt=1, glitch btn_i=0 for 2 ticks -> no release_o; long_o still fires at the next sec_tick.
- Tick/abort collision: s falls in the same cycle as the 4th sample_tick in DEB_PRESS -> state returns to 00, no press_o.
- Autorepeat (BTN_AUTOREPEAT_EN defined): hold for 5 sec_ticks -> 1 initial press_o, long_o at sec_tick 2, extra press_o at sec_ticks 3, 4 and 5. Macro undefined -> only 1 press_o.
